// File: rtl/bp_sacc_vdp_driver.sv
// Command sequencer for the vector dot-product accelerator: programs CSRs, polls status, reads back the result.
// Optional macro BP_SACC_VDP_DRIVER_TIMEOUT_EN bounds polling to max_polls_p status reads.
module bp_sacc_vdp_driver #(
  parameter int paddr_width_p  = 40,
  parameter int lce_id_width_p = 4,
  parameter int poll_gap_p     = 8,
  parameter int max_polls_p    = 256,
  localparam int cce_mem_msg_width_lp = 4 + 4 + paddr_width_p + 3 + lce_id_width_p + 64
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic [lce_id_width_p-1:0]       lce_id_i,
  input  logic                            job_v_i,
  output logic                            job_ready_o,
  input  logic [63:0]                     job_a_ptr_i,
  input  logic [63:0]                     job_b_ptr_i,
  input  logic [3:0]                      job_len_i,
  input  logic [63:0]                     job_res_ptr_i,
  output logic [cce_mem_msg_width_lp-1:0] io_cmd_o,
  output logic                            io_cmd_v_o,
  input  logic                            io_cmd_ready_i,
  input  logic [cce_mem_msg_width_lp-1:0] io_resp_i,
  input  logic                            io_resp_v_i,
  output logic                            io_resp_yumi_o,
  output logic [63:0]                     result_o,
  output logic                            result_v_o,
  input  logic                            result_yumi_i,
  output logic                            error_o,
  output logic [3:0]                      state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready (or yumi) are both high;
  // a producer holds valid and its payload stable until that edge.

  localparam int DID_W = 4;
  localparam int OFF_W = paddr_width_p - DID_W;
  localparam int GAP_W = (poll_gap_p > 1) ? $clog2(poll_gap_p + 1) : 1;
  localparam logic [3:0] UC_RD  = 4'd2;
  localparam logic [3:0] UC_WR  = 4'd3;
  localparam logic [2:0] SIZE_8 = 3'd3;

  typedef struct packed {
    logic [3:0]                msg_type;
    logic [3:0]                subop;
    logic [paddr_width_p-1:0]  addr;
    logic [2:0]                size;
    logic [lce_id_width_p-1:0] lce_id;
    logic [63:0]               data;
  } msg_s;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_WR_CSR    = 4'd1,
    S_WR_WAIT   = 4'd2,
    S_GAP       = 4'd3,
    S_POLL      = 4'd4,
    S_POLL_WAIT = 4'd5,
    S_RD_RES    = 4'd6,
    S_RD_WAIT   = 4'd7,
    S_OUT       = 4'd8
  } state_e;

  state_e           state_r;
  msg_s             cmd_r;
  logic [2:0]       idx_r;
  logic [GAP_W-1:0] gap_cnt_r;
  logic             seen_busy_r;
  logic [63:0]      a_ptr_r, b_ptr_r, res_ptr_r;
  logic [3:0]       len_r;
  logic [63:0]      resp_data;

`ifdef BP_SACC_VDP_DRIVER_TIMEOUT_EN
  localparam int PC_W = $clog2(max_polls_p + 1);
  logic [PC_W-1:0] poll_cnt_r;
`else
  logic unused_cfg;
  assign unused_cfg = ^max_polls_p;
`endif

  logic unused_resp;
  assign unused_resp = ^io_resp_i[cce_mem_msg_width_lp-1:64];

  assign resp_data      = io_resp_i[63:0];
  assign io_cmd_o       = cmd_r;
  assign io_resp_yumi_o = io_resp_v_i;
  assign state_o        = state_r;

  function automatic msg_s make_cmd(input logic [3:0] t, input logic did, input logic [OFF_W-1:0] off,
                                    input logic [63:0] d, input logic [lce_id_width_p-1:0] lce);
    msg_s m;
    m          = '0;
    m.msg_type = t;
    m.addr     = {DID_W'(did), off};
    m.size     = SIZE_8;
    m.lce_id   = lce;
    m.data     = d;
    return m;
  endfunction

  // CSR programming order; start goes last so the accelerator sees a complete descriptor.
  function automatic msg_s csr_cmd(input logic [2:0] i);
    case (i)
      3'd0:    return make_cmd(UC_WR, 1'b0, OFF_W'(12'h000), a_ptr_r, lce_id_i);
      3'd1:    return make_cmd(UC_WR, 1'b0, OFF_W'(12'h040), b_ptr_r, lce_id_i);
      3'd2:    return make_cmd(UC_WR, 1'b0, OFF_W'(12'h080), {60'd0, len_r}, lce_id_i);
      3'd3:    return make_cmd(UC_WR, 1'b0, OFF_W'(12'h140), res_ptr_r, lce_id_i);
      3'd4:    return make_cmd(UC_WR, 1'b0, OFF_W'(12'h180), 64'd1, lce_id_i);
      default: return make_cmd(UC_WR, 1'b0, OFF_W'(12'h0c0), 64'd1, lce_id_i);
    endcase
  endfunction

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r     <= S_IDLE;
      cmd_r       <= '0;
      idx_r       <= '0;
      gap_cnt_r   <= '0;
      seen_busy_r <= 1'b0;
      a_ptr_r     <= '0;
      b_ptr_r     <= '0;
      res_ptr_r   <= '0;
      len_r       <= '0;
      job_ready_o <= 1'b1;
      io_cmd_v_o  <= 1'b0;
      result_o    <= '0;
      result_v_o  <= 1'b0;
      error_o     <= 1'b0;
`ifdef BP_SACC_VDP_DRIVER_TIMEOUT_EN
      poll_cnt_r  <= '0;
`endif
    end else begin
      error_o <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (job_v_i && job_ready_o) begin
            a_ptr_r   <= job_a_ptr_i;
            b_ptr_r   <= job_b_ptr_i;
            len_r     <= job_len_i;
            res_ptr_r <= job_res_ptr_i;
            if (job_len_i == 4'd0 || job_len_i > 4'd8) begin
              error_o <= 1'b1;
            end else begin
              state_r     <= S_WR_CSR;
              job_ready_o <= 1'b0;
              idx_r       <= 3'd0;
              cmd_r       <= make_cmd(UC_WR, 1'b0, OFF_W'(12'h000), job_a_ptr_i, lce_id_i);
              io_cmd_v_o  <= 1'b1;
`ifdef BP_SACC_VDP_DRIVER_TIMEOUT_EN
              poll_cnt_r  <= '0;
`endif
            end
          end
        end
        S_WR_CSR: begin
          if (io_cmd_ready_i) begin
            io_cmd_v_o <= 1'b0;
            state_r    <= S_WR_WAIT;
          end
        end
        S_WR_WAIT: begin
          if (io_resp_v_i) begin
            if (idx_r == 3'd5) begin
              state_r     <= S_GAP;
              gap_cnt_r   <= '0;
              seen_busy_r <= 1'b0;
            end else begin
              idx_r      <= idx_r + 3'd1;
              cmd_r      <= csr_cmd(idx_r + 3'd1);
              io_cmd_v_o <= 1'b1;
              state_r    <= S_WR_CSR;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt_r == GAP_W'(poll_gap_p - 1)) begin
            gap_cnt_r  <= '0;
            cmd_r      <= make_cmd(UC_RD, 1'b0, OFF_W'(12'h100), 64'd0, lce_id_i);
            io_cmd_v_o <= 1'b1;
            state_r    <= S_POLL;
          end else begin
            gap_cnt_r <= gap_cnt_r + GAP_W'(1);
          end
        end
        S_POLL: begin
          if (io_cmd_ready_i) begin
            io_cmd_v_o <= 1'b0;
            state_r    <= S_POLL_WAIT;
`ifdef BP_SACC_VDP_DRIVER_TIMEOUT_EN
            poll_cnt_r <= poll_cnt_r + PC_W'(1);
`endif
          end
        end
        S_POLL_WAIT: begin
          if (io_resp_v_i) begin
            if (resp_data == 64'd0) seen_busy_r <= 1'b1;
            // A nonzero status only counts once the job has been seen running.
            if (resp_data != 64'd0 && seen_busy_r) begin
              cmd_r      <= make_cmd(UC_RD, 1'b1, res_ptr_r[OFF_W-1:0], 64'd0, lce_id_i);
              io_cmd_v_o <= 1'b1;
              state_r    <= S_RD_RES;
            end
`ifdef BP_SACC_VDP_DRIVER_TIMEOUT_EN
            else if (poll_cnt_r == PC_W'(max_polls_p)) begin
              error_o     <= 1'b1;
              job_ready_o <= 1'b1;
              state_r     <= S_IDLE;
            end
`endif
            else begin
              gap_cnt_r <= '0;
              state_r   <= S_GAP;
            end
          end
        end
        S_RD_RES: begin
          if (io_cmd_ready_i) begin
            io_cmd_v_o <= 1'b0;
            state_r    <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          if (io_resp_v_i) begin
            result_o   <= resp_data;
            result_v_o <= 1'b1;
            state_r    <= S_OUT;
          end
        end
        S_OUT: begin
          if (result_yumi_i) begin
            result_v_o  <= 1'b0;
            job_ready_o <= 1'b1;
            state_r     <= S_IDLE;
          end
        end
        default: begin
          state_r     <= S_IDLE;
          io_cmd_v_o  <= 1'b0;
          job_ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bp_sacc_vdp_driver.sv
// Directed bench for bp_sacc_vdp_driver: accelerator responder model, command scoreboard, result checks.
module tb_bp_sacc_vdp_driver;

  localparam int PADDR_W = 40;
  localparam int LCE_W   = 4;
  localparam int GAP     = 8;
`ifdef BP_SACC_VDP_DRIVER_TIMEOUT_EN
  localparam int MAXP    = 4;
`else
  localparam int MAXP    = 256;
`endif
  localparam int MSG_W   = 4 + 4 + PADDR_W + 3 + LCE_W + 64;
  localparam int OFF_W   = PADDR_W - 4;
  localparam logic [LCE_W-1:0] LCE = 4'h5;
  localparam logic [3:0] UC_RD = 4'd2;
  localparam logic [3:0] UC_WR = 4'd3;
  localparam logic [3:0] ST_IDLE = 4'd0;
  localparam logic [3:0] ST_POLL_WAIT = 4'd5;

  logic             clk = 1'b0;
  logic             reset_i = 1'b1;
  logic [LCE_W-1:0] lce_id_i = LCE;
  logic             job_v_i = 1'b0;
  logic             job_ready_o;
  logic [63:0]      job_a_ptr_i = '0, job_b_ptr_i = '0, job_res_ptr_i = '0;
  logic [3:0]       job_len_i = '0;
  logic [MSG_W-1:0] io_cmd_o;
  logic             io_cmd_v_o;
  logic             io_cmd_ready_i = 1'b1;
  logic [MSG_W-1:0] io_resp_i = '0;
  logic             io_resp_v_i = 1'b0;
  logic             io_resp_yumi_o;
  logic [63:0]      result_o;
  logic             result_v_o;
  logic             result_yumi_i = 1'b0;
  logic             error_o;
  logic [3:0]       state_o;

  bp_sacc_vdp_driver #(
    .paddr_width_p(PADDR_W), .lce_id_width_p(LCE_W), .poll_gap_p(GAP), .max_polls_p(MAXP)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .lce_id_i(lce_id_i),
    .job_v_i(job_v_i), .job_ready_o(job_ready_o),
    .job_a_ptr_i(job_a_ptr_i), .job_b_ptr_i(job_b_ptr_i), .job_len_i(job_len_i),
    .job_res_ptr_i(job_res_ptr_i),
    .io_cmd_o(io_cmd_o), .io_cmd_v_o(io_cmd_v_o), .io_cmd_ready_i(io_cmd_ready_i),
    .io_resp_i(io_resp_i), .io_resp_v_i(io_resp_v_i), .io_resp_yumi_o(io_resp_yumi_o),
    .result_o(result_o), .result_v_o(result_v_o), .result_yumi_i(result_yumi_i),
    .error_o(error_o), .state_o(state_o)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [MSG_W-1:0] mk(input logic [3:0] t, input logic [3:0] did,
                                          input logic [OFF_W-1:0] off, input logic [63:0] d);
    return {t, 4'h0, did, off, 3'd3, LCE, d};
  endfunction

  // scoreboard and accelerator model
  logic [MSG_W-1:0] exp_q[$];
  logic [63:0] spm [0:63];
  logic [63:0] m_a, m_b, m_res, m_len;
  int busy_target = 0;
  int polls_seen = 0;
  int status_reads = 0;
  int last_poll = 0;
  bit rand_ready = 1'b0;
  bit resp_pend = 1'b0;
  int resp_delay = 0;
  logic [63:0] resp_data = '0;
  bit hold_chk = 1'b0;
  logic [MSG_W-1:0] prev_cmd = '0;
  int err_cnt = 0, cmdv_cnt = 0, resv_cnt = 0;

  always @(negedge clk) begin
    logic [MSG_W-1:0] got;
    logic [3:0] t, did;
    logic [OFF_W-1:0] off;
    logic [63:0] d, sum;
    if (error_o === 1'b1) err_cnt++;
    if (io_cmd_v_o === 1'b1) cmdv_cnt++;
    if (result_v_o === 1'b1) resv_cnt++;
    if (io_resp_v_i) check("resp_yumi", io_resp_yumi_o, 1);
    io_resp_v_i = 1'b0;
    if (resp_pend) begin
      resp_delay--;
      if (resp_delay == 0) begin
        io_resp_v_i = 1'b1;
        io_resp_i = {UC_RD, 4'h0, 40'd0, 3'd3, LCE, resp_data};
        resp_pend = 1'b0;
      end
    end
    io_cmd_ready_i = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (hold_chk && io_cmd_v_o) check("cmd_stable", io_cmd_o, prev_cmd);
    hold_chk = 1'b0;
    if (io_cmd_v_o === 1'b1 && !reset_i) begin
      if (!io_cmd_ready_i) begin
        hold_chk = 1'b1;
        prev_cmd = io_cmd_o;
      end else begin
        got = io_cmd_o;
        if (exp_q.size() == 0) check("cmd_extra", got, '0);
        else check("cmd_seq", got, exp_q.pop_front());
        t   = got[MSG_W-1 -: 4];
        did = got[MSG_W-9 -: 4];
        off = got[MSG_W-13 -: OFF_W];
        d   = got[63:0];
        resp_data = '0;
        if (t == UC_WR && did == 4'd0) begin
          case (off)
            36'h000: m_a = d;
            36'h040: m_b = d;
            36'h080: m_len = d;
            36'h140: m_res = d;
            36'h0c0: begin
              sum = '0;
              for (int i = 0; i < int'(m_len); i++)
                sum += spm[int'(m_a >> 3) + i] * spm[int'(m_b >> 3) + i];
              spm[int'(m_res >> 3)] = sum;
              polls_seen = 0;
              status_reads = 0;
            end
            default: ;
          endcase
        end else if (t == UC_RD && did == 4'd0 && off == 36'h100) begin
          status_reads++;
          if (status_reads > 1) check("poll_gap", (cyc - last_poll) >= GAP, 1);
          last_poll = cyc;
          resp_data = (polls_seen < busy_target) ? 64'd0 : 64'd1;
          polls_seen++;
        end else if (t == UC_RD && did == 4'd1) begin
          resp_data = spm[int'(off >> 3)];
        end
        resp_pend = 1'b1;
        resp_delay = $urandom_range(1, 3);
      end
    end
  end

  // driver tasks
  task automatic push_job(input logic [63:0] a, b, input logic [3:0] len, input logic [63:0] res,
                          input int npolls, input bit rd);
    exp_q.push_back(mk(UC_WR, 4'd0, 36'h000, a));
    exp_q.push_back(mk(UC_WR, 4'd0, 36'h040, b));
    exp_q.push_back(mk(UC_WR, 4'd0, 36'h080, {60'd0, len}));
    exp_q.push_back(mk(UC_WR, 4'd0, 36'h140, res));
    exp_q.push_back(mk(UC_WR, 4'd0, 36'h180, 64'd1));
    exp_q.push_back(mk(UC_WR, 4'd0, 36'h0c0, 64'd1));
    for (int i = 0; i < npolls; i++) exp_q.push_back(mk(UC_RD, 4'd0, 36'h100, 64'd0));
    if (rd) exp_q.push_back(mk(UC_RD, 4'd1, res[OFF_W-1:0], 64'd0));
  endtask

  task automatic run_job(input logic [63:0] a, b, input logic [3:0] len, input logic [63:0] res);
    job_a_ptr_i = a;
    job_b_ptr_i = b;
    job_len_i = len;
    job_res_ptr_i = res;
    job_v_i = 1'b1;
    check("job_ready_before", job_ready_o, 1);
    @(negedge clk);
    job_v_i = 1'b0;
  endtask

  task automatic wait_result(input logic [63:0] exp);
    int n, e0;
    n = 0;
    while (result_v_o !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("result_valid", result_v_o, 1);
    check("result_value", result_o, exp);
    repeat (3) @(negedge clk);
    check("result_held_v", result_v_o, 1);
    check("result_held_d", result_o, exp);
    check("busy_not_ready", job_ready_o, 0);
    result_yumi_i = 1'b1;
    job_v_i = 1'b1;
    job_len_i = 4'd0;
    e0 = err_cnt;
    @(negedge clk);
    result_yumi_i = 1'b0;
    job_v_i = 1'b0;
    check("result_cleared", result_v_o, 0);
    check("ready_after_yumi", job_ready_o, 1);
    repeat (3) @(negedge clk);
    check("no_accept_in_out", err_cnt - e0, 0);
    check("cmd_all_seen", exp_q.size(), 0);
  endtask

  initial begin
    int e0, c0, r0, n;
    for (int i = 0; i < 64; i++) spm[i] = '0;
    for (int i = 0; i < 4; i++) begin
      spm[i] = 64'(i + 1);
      spm[8 + i] = 64'(i + 5);
    end
    for (int i = 0; i < 8; i++) begin
      spm[32 + i] = 64'(i + 1);
      spm[40 + i] = 64'(i + 1);
    end
    repeat (3) @(negedge clk);
    check("rst_job_ready", job_ready_o, 1);
    check("rst_cmd_v", io_cmd_v_o, 0);
    check("rst_result_v", result_v_o, 0);
    check("rst_error", error_o, 0);
    check("rst_state", state_o, ST_IDLE);
    reset_i = 1'b0;
    @(negedge clk);

    // 1: basic job, start latency, CSR order
    busy_target = 2;
    push_job(64'h0, 64'h40, 4'd4, 64'h80, 3, 1'b1);
    run_job(64'h0, 64'h40, 4'd4, 64'h80);
    check("start_latency", io_cmd_v_o, 1);
    wait_result(64'd70);

    // 2: len 8 with backpressure on commands
    rand_ready = 1'b1;
    busy_target = 2;
    push_job(64'h100, 64'h140, 4'd8, 64'h1c0, 3, 1'b1);
    run_job(64'h100, 64'h140, 4'd8, 64'h1c0);
    wait_result(64'd204);
    rand_ready = 1'b0;

    // 3: illegal lengths
    e0 = err_cnt;
    c0 = cmdv_cnt;
    run_job(64'h0, 64'h40, 4'd0, 64'h80);
    check("err_pulse_len0", error_o, 1);
    @(negedge clk);
    check("err_one_cycle_len0", error_o, 0);
    check("ready_after_len0", job_ready_o, 1);
    run_job(64'h0, 64'h40, 4'd9, 64'h80);
    check("err_pulse_len9", error_o, 1);
    repeat (4) @(negedge clk);
    check("ready_after_len9", job_ready_o, 1);
    check("err_count_illegal", err_cnt - e0, 2);
    check("no_cmd_illegal", cmdv_cnt - c0, 0);

`ifndef BP_SACC_VDP_DRIVER_TIMEOUT_EN
    // 4: long busy period, 21 status reads
    busy_target = 20;
    push_job(64'h0, 64'h40, 4'd4, 64'h80, 21, 1'b1);
    run_job(64'h0, 64'h40, 4'd4, 64'h80);
    wait_result(64'd70);
    check("status_reads_21", status_reads, 21);
`else
    // 5: timeout after max_polls_p status reads
    busy_target = 1000;
    push_job(64'h0, 64'h40, 4'd4, 64'h80, MAXP, 1'b0);
    r0 = resv_cnt;
    e0 = err_cnt;
    run_job(64'h0, 64'h40, 4'd4, 64'h80);
    n = 0;
    while (error_o !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("timeout_err", error_o, 1);
    check("timeout_polls", status_reads, MAXP);
    repeat (20) @(negedge clk);
    check("timeout_err_once", err_cnt - e0, 1);
    check("timeout_no_result", resv_cnt - r0, 0);
    check("timeout_idle_ready", job_ready_o, 1);
    check("timeout_cmds", exp_q.size(), 0);
`endif

    // 6: reset during POLL_WAIT, then a clean job
    busy_target = 5;
    push_job(64'h0, 64'h40, 4'd4, 64'h80, 6, 1'b1);
    run_job(64'h0, 64'h40, 4'd4, 64'h80);
    n = 0;
    while (!(state_o == ST_POLL_WAIT && status_reads >= 2) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("reached_poll_wait", state_o, ST_POLL_WAIT);
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    check("midrst_ready", job_ready_o, 1);
    check("midrst_cmd_v", io_cmd_v_o, 0);
    check("midrst_state", state_o, ST_IDLE);
    exp_q.delete();
    repeat (5) @(negedge clk);
    check("stale_resp_ignored", state_o, ST_IDLE);
    busy_target = 1;
    push_job(64'h0, 64'h40, 4'd4, 64'h80, 2, 1'b1);
    run_job(64'h0, 64'h40, 4'd4, 64'h80);
    wait_result(64'd70);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
